// File: rtl/cert_chain_ctrl_pkg.sv
// Shared definitions for the certificate-chain fetch controller.
// Holds FSM state encoding, error codes, header layout and default message constants.
package cert_chain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_REQ,
    ST_WAIT_RSP,
    ST_CHECK,
    ST_WAIT_CMP,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_HDR     = 3'd1;
  localparam logic [2:0] ERR_COUNT   = 3'd2;
  localparam logic [2:0] ERR_CERT    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [7:0] DEF_PROTO_VER = 8'h01;
  localparam logic [7:0] DEF_RSP_TYPE  = 8'h02;
  localparam logic [7:0] DEF_REQ_TYPE  = 8'h82;

  // Message header: ProtocolVersion in the upper byte, MessageType in the lower byte.
  typedef struct packed {
    logic [7:0] ver;
    logic [7:0] mtype;
  } hdr_t;

endpackage

// File: rtl/cert_chain_ctrl_if.sv
// Request/response channel between the chain controller and the message transport.
// master: controller side (drives req_valid/req_msg/rsp_ready).
// slave : transport side (drives req_ready/rsp_valid/rsp_msg).
interface cert_chain_ctrl_if #(
  parameter int unsigned MSG_W = 2080
) ();
  logic             req_valid;
  logic             req_ready;
  logic [MSG_W-1:0] req_msg;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [MSG_W-1:0] rsp_msg;

  modport master (
    output req_valid, req_msg, rsp_ready,
    input  req_ready, rsp_valid, rsp_msg
  );

  modport slave (
    input  req_valid, req_msg, rsp_ready,
    output req_ready, rsp_valid, rsp_msg
  );
endinterface

// File: rtl/cert_rsp_timer.sv
// Response timeout counter and per-index retry counter.
// Ports: clk, reset (sync, active-low); tmr_clr/tmr_en control the timer,
// retry_clr/retry_inc control the retry count; expire_c flags the last wait
// cycle, exhausted_c flags that no resends remain.
module cert_rsp_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tmr_clr,
  input  logic tmr_en,
  input  logic retry_clr,
  input  logic retry_inc,
  output logic expire_c,
  output logic exhausted_c
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [TMR_W-1:0] tmr_q;
  logic [RTY_W-1:0] retry_q;

  assign expire_c    = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign exhausted_c = (retry_q >= RTY_W'(MAX_RETRIES));

  // Timer saturates at the expiry value so it never wraps while unattended.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q <= '0;
    end else if (tmr_clr) begin
      tmr_q <= '0;
    end else if (tmr_en && !expire_c) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retry_q <= '0;
    end else if (retry_clr) begin
      retry_q <= '0;
    end else if (retry_inc && !exhausted_c) begin
      retry_q <= retry_q + RTY_W'(1);
    end
  end

endmodule

// File: rtl/cert_chain_ctrl.sv
// Certificate-chain fetch controller: requests each chain index for a slot,
// validates response headers and the announced chain length, and hands each
// payload to an external comparator. Timeout with bounded retry per index.
// Ports: clk, reset (sync, active-low), start/slot (fetch request),
// bus (request/response channel, master side), cmp_* (comparator handshake),
// busy/done/failed/err_code/certs_ok (status).
module cert_chain_ctrl
  import cert_chain_ctrl_pkg::*;
#(
  parameter int unsigned MSG_W       = 2080,
  parameter int unsigned HDR_W       = 16,
  parameter int unsigned SLOT_W      = 2,
  parameter int unsigned MAX_CERTS   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRIES = 3,
  parameter logic [7:0]  PROTO_VER   = DEF_PROTO_VER,
  parameter logic [7:0]  RSP_TYPE    = DEF_RSP_TYPE,
  parameter logic [7:0]  REQ_TYPE    = DEF_REQ_TYPE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SLOT_W-1:0]      slot,
  cert_chain_ctrl_if.master      bus,
  output logic                   cmp_start,
  output logic [7:0]             cmp_index,
  output logic [MSG_W-HDR_W-1:0] cmp_payload,
  input  logic                   cmp_valid,
  input  logic                   cmp_pass,
  output logic                   busy,
  output logic                   done,
  output logic                   failed,
  output logic [2:0]             err_code,
  output logic [7:0]             certs_ok
);

  localparam int unsigned PAY_W = MSG_W - HDR_W;
  localparam hdr_t REQ_HDR = '{ver: PROTO_VER, mtype: REQ_TYPE};
  localparam hdr_t RSP_HDR = '{ver: PROTO_VER, mtype: RSP_TYPE};

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [7:0]          index_q, index_d;
  logic [7:0]          expected_q, expected_d;
  logic [HDR_W-1:0]    hdr_q;
  logic                busy_d, done_d, failed_d, cmp_start_d;
  logic [2:0]          err_d;
  logic [7:0]          certs_d, cmp_index_d;
  logic                req_valid_q, rsp_ready_q;
  logic [MSG_W-1:0]    req_msg_q;
  logic                capture;
  logic                tmr_clr, tmr_en, retry_clr, retry_inc;
  logic                expire_c, exhausted_c;
  logic [7:0]          count_c;

  assign bus.req_valid = req_valid_q;
  assign bus.req_msg   = req_msg_q;
  assign bus.rsp_ready = rsp_ready_q;

  // Chain length announced in the top byte of the first response payload.
  assign count_c = cmp_payload[PAY_W-1 -: 8];

  cert_rsp_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRIES (MAX_RETRIES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .tmr_clr     (tmr_clr),
    .tmr_en      (tmr_en),
    .retry_clr   (retry_clr),
    .retry_inc   (retry_inc),
    .expire_c    (expire_c),
    .exhausted_c (exhausted_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    index_d     = index_q;
    expected_d  = expected_q;
    busy_d      = busy;
    done_d      = done;
    failed_d    = failed;
    err_d       = err_code;
    certs_d     = certs_ok;
    cmp_start_d = 1'b0;
    cmp_index_d = cmp_index;
    capture     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    retry_clr   = 1'b0;
    retry_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          slot_d     = slot;
          index_d    = 8'd1;
          expected_d = 8'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          failed_d   = 1'b0;
          err_d      = ERR_NONE;
          certs_d    = 8'd0;
          retry_clr  = 1'b1;
          state_d    = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: begin
        if (req_valid_q && bus.req_ready) begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        tmr_en = 1'b1;
        // A response arriving on the expiry cycle still wins.
        if (bus.rsp_valid) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end else if (expire_c) begin
          if (!exhausted_c) begin
            retry_inc = 1'b1;
            state_d   = ST_SEND_REQ;
          end else begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_FAIL;
          end
        end
      end
      ST_CHECK: begin
        if (hdr_q != HDR_W'(RSP_HDR)) begin
          err_d   = ERR_HDR;
          state_d = ST_FAIL;
        end else if ((index_q == 8'd1) &&
                     ((count_c == 8'd0) || (32'(count_c) > MAX_CERTS))) begin
          err_d   = ERR_COUNT;
          state_d = ST_FAIL;
        end else begin
          if (index_q == 8'd1) begin
            expected_d = count_c;
          end
          cmp_start_d = 1'b1;
          cmp_index_d = index_q;
          state_d     = ST_WAIT_CMP;
        end
      end
      ST_WAIT_CMP: begin
        if (cmp_valid) begin
          if (cmp_pass) begin
            certs_d = certs_ok + 8'd1;
            state_d = ST_NEXT;
          end else begin
            err_d   = ERR_CERT;
            state_d = ST_FAIL;
          end
        end
      end
      ST_NEXT: begin
        if (index_q == expected_q) begin
          state_d = ST_DONE;
        end else begin
          index_d   = index_q + 8'd1;
          retry_clr = 1'b1;
          state_d   = ST_SEND_REQ;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        failed_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      index_q     <= '0;
      expected_q  <= '0;
      hdr_q       <= '0;
      cmp_payload <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      failed      <= 1'b0;
      err_code    <= ERR_NONE;
      certs_ok    <= '0;
      cmp_start   <= 1'b0;
      cmp_index   <= '0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      req_msg_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      index_q     <= index_d;
      expected_q  <= expected_d;
      busy        <= busy_d;
      done        <= done_d;
      failed      <= failed_d;
      err_code    <= err_d;
      certs_ok    <= certs_d;
      cmp_start   <= cmp_start_d;
      cmp_index   <= cmp_index_d;
      req_valid_q <= (state_d == ST_SEND_REQ);
      rsp_ready_q <= (state_d == ST_WAIT_RSP);
      req_msg_q   <= {HDR_W'(REQ_HDR), PAY_W'({slot_d, index_d})};
      if (capture) begin
        hdr_q       <= bus.rsp_msg[MSG_W-1 -: HDR_W];
        cmp_payload <= bus.rsp_msg[PAY_W-1:0];
      end
    end
  end

endmodule

// File: doc/cert_chain_ctrl.md
Name: cert_chain_ctrl

Overview:
- Parametrised successor to the single-slot certificate-chain fetch controller of the USB Type-C authentication driver.
- Issues GET_CERTIFICATE requests over a valid/ready request channel for a selected slot, one chain index at a time.
- Validates each response header and hands the payload to an external certificate comparator; also validates the chain length announced in the first response.
- Adds per-request timeout with bounded retry, explicit error codes, and a configurable chain depth.
- Sits between the authentication top-level FSM and the message transport.

Parameters:
MSG_W, 2080, total message width (header + payload)
HDR_W, 16, header width (ProtocolVersion byte, MessageType byte)
SLOT_W, 2, slot select width
MAX_CERTS, 8, maximum accepted chain length (1..255)
TIMEOUT_CYC, 1024, cycles to wait for a response before a retry
MAX_RETRIES, 3, resends per index before failure
PROTO_VER, 8'h01, required ProtocolVersion in responses
RSP_TYPE, 8'h02, required MessageType in responses
REQ_TYPE, 8'h82, MessageType placed in requests

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  single-cycle pulse; begins a chain fetch when idle
slot  in  SLOT_W  slot to fetch; sampled on start
req_valid  out  1  request message valid
req_ready  in  1  transport accepts request
req_msg  out  MSG_W  {PROTO_VER, REQ_TYPE, payload}; payload LSBs = {slot, index[7:0]}, remaining bits 0
rsp_valid  in  1  response message valid
rsp_ready  out  1  controller accepts response
rsp_msg  in  MSG_W  response message
cmp_start  out  1  one-cycle pulse to the comparator
cmp_index  out  8  chain index being checked (1-based)
cmp_payload  out  MSG_W-HDR_W  registered response payload
cmp_valid  in  1  comparator result strobe
cmp_pass  in  1  comparator verdict, qualified by cmp_valid
busy  out  1  fetch in progress
done  out  1  sticky success
failed  out  1  sticky failure
err_code  out  3  0 none, 1 bad header, 2 bad count, 3 cert invalid, 4 timeout
certs_ok  out  8  number of certificates validated so far

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; counters cleared. Applies mid-operation; no request is left asserted.
- States: IDLE, SEND_REQ, WAIT_RSP, CHECK, WAIT_CMP, NEXT, DONE, FAIL.
- IDLE: on start, latch slot, index=1, retry=0, expected=0; clear done/failed/err_code/certs_ok; busy=1; go to SEND_REQ.
- start while busy is ignored.
- SEND_REQ: hold req_valid=1 with a stable req_msg until req_valid&&req_ready; then clear timer and go to WAIT_RSP.
- WAIT_RSP: rsp_ready=1. Timer increments each cycle.
  - On rsp_valid, capture rsp_msg (handshake cycle) and go to CHECK.
  - If the timer reaches TIMEOUT_CYC-1 without a response: if retry<MAX_RETRIES, retry++ and go to SEND_REQ; otherwise err=4 and go to FAIL.
  - rsp_valid in the same cycle as the timeout wins (response accepted).
- CHECK (1 cycle):
  - Header must equal {PROTO_VER, RSP_TYPE}; otherwise err=1, FAIL.
  - When index==1: expected = payload[MSB-:8]. expected==0 or expected>MAX_CERTS gives err=2, FAIL.
  - Otherwise pulse cmp_start, drive cmp_index=index, and go to WAIT_CMP.
- WAIT_CMP: wait for cmp_valid, with no timeout.
  - cmp_pass=1: certs_ok++, go to NEXT.
  - cmp_pass=0: err=3, FAIL.
- NEXT: if index==expected, go to DONE; otherwise index++, retry=0, go to SEND_REQ.
- DONE: done=1, busy=0, go to IDLE. FAIL: failed=1, busy=0, go to IDLE. done/failed/err_code hold until the next accepted start.
- rsp_valid outside WAIT_RSP: rsp_ready=0, message not consumed.
- cmp_valid outside WAIT_CMP is ignored.
- Counters: index and certs_ok are 8-bit and cannot wrap because expected<=MAX_CERTS<=255. Timer width is $clog2(TIMEOUT_CYC); retry width is $clog2(MAX_RETRIES+1).
- Latency: minimum start-to-done for N=1 is 7 cycles with req_ready, rsp_valid and cmp_valid all immediate.

Decomposition:
- Shared package/include: error-code constants, PROTO_VER/RSP_TYPE/REQ_TYPE defaults, header field offsets, state encodings.
- One natural sub-module, cert_rsp_timer: timeout counter plus retry counter with clear/expire outputs.

Test Plan:
- Chain of 3, slot=2, all immediate → 3 requests with index 1,2,3 and slot 2; certs_ok=3; done=1; err_code=0.
- Response header 8'h01,8'h03 on index 1 → failed=1, err_code=1, no cmp_start.
- First response count byte = 0, then 9 (MAX_CERTS=8) → err_code=2 in both runs.
- cmp_pass=0 on index 2 of 4 → failed=1, err_code=3, certs_ok=1.
- No response for 2 timeouts, then a response → 3 identical index-1 requests, completes normally. No response at all → 4 requests, then err_code=4.
- reset=0 asserted during WAIT_CMP → all outputs 0 next cycle. A following start restarts at index 1.
- start pulsed while busy → ignored, no state change.
